// File: rtl/memory_responder.sv
// memory_responder: instruction/data memory for the 16-bit single-cycle datapath, with a boot loader.
// Latency: reads are combinational from PC / Data_ad. Stores, loader beats and clear writes commit at the rising edge.
// Backpressure: Load_ready is high only in LOAD. Once loading ends, beats are refused. Cpu_run holds the CPU until dmem is cleared.
// Ports: Clock, Reset (sync, active-low); PC -> Instruction; Data_ad/Data_wdata/Data_write -> Data_out;
//        Load_valid/Load_data/Load_last -> Load_ready; Cpu_run (CPU release); Dmem_oob (sticky out-of-range flag).
module memory_responder #(
  parameter int N       = 16,
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [N-1:0] PC,
  output logic [N-1:0] Instruction,
  input  logic [N-1:0] Data_ad,
  input  logic [N-1:0] Data_wdata,
  input  logic         Data_write,
  output logic [N-1:0] Data_out,
  input  logic         Load_valid,
  input  logic [N-1:0] Load_data,
  input  logic         Load_last,
  output logic         Load_ready,
  output logic         Cpu_run,
  output logic         Dmem_oob
);

  typedef enum logic [1:0] {S_LOAD, S_CLEAR, S_RUN} state_t;

  localparam logic [IMEM_AW-1:0] IMEM_LAST = '1;
  localparam logic [DMEM_AW-1:0] DMEM_LAST = '1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IMEM_AW-1:0] r_load_ptr;
  logic [DMEM_AW-1:0] r_clr_ptr;
  logic               r_oob;
  logic [N-1:0]       r_imem [0:(1<<IMEM_AW)-1];
  logic [N-1:0]       r_dmem [0:(1<<DMEM_AW)-1];

  logic w_load_fire;
  logic w_d_inrng;
  logic w_i_inrng;
  logic w_run;
  logic w_store;

  assign w_d_inrng = (Data_ad[N-1:DMEM_AW] == '0);
  assign w_i_inrng = (PC[N-1:IMEM_AW] == '0);
  assign w_run     = (r_state == S_RUN);
  assign w_store   = w_run && Data_write && w_d_inrng;

  always_comb begin
    w_state_nxt = r_state;
    Load_ready  = 1'b0;
    Cpu_run     = 1'b0;
    w_load_fire = 1'b0;
    case (r_state)
      S_LOAD: begin
        Load_ready  = 1'b1;
        w_load_fire = Load_valid;
        // The beat at the top address ends loading even without Load_last.
        // This keeps the pointer from wrapping over word 0.
        if (Load_valid && (Load_last || (r_load_ptr == IMEM_LAST))) begin
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (r_clr_ptr == DMEM_LAST) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        Cpu_run = 1'b1;
      end
      default: begin
        w_state_nxt = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state    <= S_LOAD;
      r_load_ptr <= '0;
      r_clr_ptr  <= '0;
      r_oob      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_fire) begin
        r_load_ptr <= r_load_ptr + IMEM_AW'(1);
      end
      if (r_state == S_CLEAR) begin
        r_clr_ptr <= r_clr_ptr + DMEM_AW'(1);
      end
      if (w_run && !w_d_inrng) begin
        r_oob <= 1'b1;
      end
    end
  end

  // Memory contents survive reset. A reset edge only suppresses the write at that edge.
  always_ff @(posedge Clock) begin
    if (Reset && w_load_fire) begin
      r_imem[r_load_ptr] <= Load_data;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      if (r_state == S_CLEAR) begin
        r_dmem[r_clr_ptr] <= '0;
      end else if (w_store) begin
        r_dmem[Data_ad[DMEM_AW-1:0]] <= Data_wdata;
      end
    end
  end

  // Reads come from the array as it stood before the edge.
  // A read to the address being written returns the old word.
  assign Instruction = (w_run && w_i_inrng) ? r_imem[PC[IMEM_AW-1:0]] : '0;
  assign Data_out    = (w_run && w_d_inrng) ? r_dmem[Data_ad[DMEM_AW-1:0]] : '0;
  assign Dmem_oob    = r_oob;

endmodule

// File: tb/tb_memory_responder.sv
module tb_memory_responder;

  logic        Clock;
  logic        Reset;
  logic [15:0] PC;
  logic [15:0] Instruction;
  logic [15:0] Data_ad;
  logic [15:0] Data_wdata;
  logic        Data_write;
  logic [15:0] Data_out;
  logic        Load_valid;
  logic [15:0] Load_data;
  logic        Load_last;
  logic        Load_ready;
  logic        Cpu_run;
  logic        Dmem_oob;

  memory_responder dut (
    .Clock(Clock), .Reset(Reset),
    .PC(PC), .Instruction(Instruction),
    .Data_ad(Data_ad), .Data_wdata(Data_wdata), .Data_write(Data_write), .Data_out(Data_out),
    .Load_valid(Load_valid), .Load_data(Load_data), .Load_last(Load_last), .Load_ready(Load_ready),
    .Cpu_run(Cpu_run), .Dmem_oob(Dmem_oob)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       nm;
    logic [15:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [15:0] ad;
    logic        wr;
    logic [15:0] wd;
    logic [15:0] pc;
    logic [15:0] e_dout;
    logic [15:0] e_instr;
    logic        e_oob;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Compare Data_out against the oldest outstanding expectation.
  task automatic sb_pop_check();
    sb_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_underflow: got empty queue expected an entry");
    end else begin
      e = sb_q.pop_front();
      chk(e.nm, {16'h0, Data_out}, {16'h0, e.exp});
    end
  endtask

  // Count edges from the current (post-final-beat) cycle until Cpu_run rises; bounded.
  task automatic wait_boot(output int cnt);
    cnt = 0;
    do begin
      @(posedge Clock);
      cnt++;
      @(negedge Clock);
    end while (!Cpu_run && cnt < 400);
  endtask

  task automatic rd_instr(input logic [15:0] pc, input logic [15:0] exp, input string nm);
    @(negedge Clock);
    PC = pc;
    #1;
    chk(nm, {16'h0, Instruction}, {16'h0, exp});
  endtask

  task automatic sweep_dmem(input string tag);
    for (int a = 0; a < 256; a++) begin
      @(negedge Clock);
      Data_ad = a[15:0];
      sb_q.push_back('{$sformatf("%s_%0d", tag, a), 16'h0000});
      #1;
      sb_pop_check();
    end
  endtask

  initial begin
    int cnt;
    logic [15:0] beats [3];

    vt[0]  = '{16'd5,    1'b1, 16'hBEEF, 16'd1,    16'h0000, 16'h2222, 1'b0};
    vt[1]  = '{16'd5,    1'b0, 16'h0000, 16'd2,    16'hBEEF, 16'h3333, 1'b0};
    vt[2]  = '{16'd6,    1'b0, 16'h0000, 16'd0,    16'h0000, 16'h1111, 1'b0};
    vt[3]  = '{16'd0,    1'b1, 16'h1234, 16'd1,    16'h0000, 16'h2222, 1'b0};
    vt[4]  = '{16'd0,    1'b0, 16'h0000, 16'd1,    16'h1234, 16'h2222, 1'b0};
    vt[5]  = '{16'h0100, 1'b1, 16'hFFFF, 16'h0100, 16'h0000, 16'h0000, 1'b0};
    vt[6]  = '{16'd0,    1'b0, 16'h0000, 16'd0,    16'h1234, 16'h1111, 1'b1};
    vt[7]  = '{16'h0100, 1'b0, 16'h0000, 16'd2,    16'h0000, 16'h3333, 1'b1};
    vt[8]  = '{16'd200,  1'b1, 16'hCAFE, 16'd0,    16'h0000, 16'h1111, 1'b1};
    vt[9]  = '{16'd200,  1'b0, 16'h0000, 16'hFFFF, 16'hCAFE, 16'h0000, 1'b1};
    vt[10] = '{16'hFFFF, 1'b1, 16'h5A5A, 16'd1,    16'h0000, 16'h2222, 1'b1};
    vt[11] = '{16'd255,  1'b0, 16'h0000, 16'd1,    16'h0000, 16'h2222, 1'b1};

    beats[0] = 16'h1111;
    beats[1] = 16'h2222;
    beats[2] = 16'h3333;

    Reset = 1'b0; PC = '0; Data_ad = '0; Data_wdata = '0; Data_write = 1'b0;
    Load_valid = 1'b0; Load_data = '0; Load_last = 1'b0;

    // Reset state.
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    #1;
    chk("rst_load_ready", {31'h0, Load_ready}, 32'h1);
    chk("rst_cpu_run",    {31'h0, Cpu_run},    32'h0);
    chk("rst_oob",        {31'h0, Dmem_oob},   32'h0);
    chk("rst_instr",      {16'h0, Instruction}, 32'h0);
    chk("rst_dout",       {16'h0, Data_out},    32'h0);
    Reset = 1'b1;

    // Three-beat load with gaps between beats.
    for (int b = 0; b < 3; b++) begin
      @(negedge Clock);
      Load_valid = 1'b1; Load_data = beats[b]; Load_last = (b == 2);
      #1;
      chk($sformatf("load_ready_beat%0d", b), {31'h0, Load_ready}, 32'h1);
      if (b < 2) begin
        @(negedge Clock);
        Load_valid = 1'b0;
        #1;
        chk($sformatf("load_ready_gap%0d", b), {31'h0, Load_ready}, 32'h1);
      end
    end
    @(negedge Clock);
    Load_valid = 1'b0; Load_last = 1'b0;
    #1;
    chk("ready_fall", {31'h0, Load_ready}, 32'h0);
    chk("run_low_clear", {31'h0, Cpu_run}, 32'h0);
    wait_boot(cnt);
    chk("boot1_cycles", cnt, 32'd256);

    rd_instr(16'd0, 16'h1111, "instr_pc0");
    rd_instr(16'd1, 16'h2222, "instr_pc1");
    rd_instr(16'd2, 16'h3333, "instr_pc2");
    rd_instr(16'h0100, 16'h0000, "instr_oob");
    sweep_dmem("clr1");

    // Stores, read-during-write, out-of-range; the loader is held valid and must be ignored.
    for (int i = 0; i < 12; i++) begin
      @(negedge Clock);
      Data_ad = vt[i].ad; Data_write = vt[i].wr; Data_wdata = vt[i].wd; PC = vt[i].pc;
      Load_valid = 1'b1; Load_data = 16'hBAD0;
      sb_q.push_back('{$sformatf("vec%0d_dout", i), vt[i].e_dout});
      #1;
      sb_pop_check();
      chk($sformatf("vec%0d_instr", i), {16'h0, Instruction}, {16'h0, vt[i].e_instr});
      chk($sformatf("vec%0d_oob", i), {31'h0, Dmem_oob}, {31'h0, vt[i].e_oob});
    end
    @(negedge Clock);
    Data_write = 1'b0;
    #1;
    chk("run_no_ready", {31'h0, Load_ready}, 32'h0);
    Load_valid = 1'b0;
    rd_instr(16'd0, 16'h1111, "instr_after_ignored_load");

    // Reset from RUN, then a full 256-beat load with no Load_last and valid held high.
    @(negedge Clock);
    Reset = 1'b0; Data_write = 1'b1; Data_ad = 16'd9; Data_wdata = 16'h9999;
    @(negedge Clock);
    #1;
    chk("rst_run_cpu_run", {31'h0, Cpu_run}, 32'h0);
    chk("rst_run_oob", {31'h0, Dmem_oob}, 32'h0);
    Reset = 1'b1; Data_write = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge Clock);
      Load_valid = 1'b1; Load_data = 16'h8000 | i[15:0]; Load_last = 1'b0;
      #1;
      if (i == 0 || i == 128 || i == 255)
        chk($sformatf("full_ready_%0d", i), {31'h0, Load_ready}, 32'h1);
    end
    @(negedge Clock);
    Load_data = 16'hEEEE;
    #1;
    chk("beat257_refused", {31'h0, Load_ready}, 32'h0);
    repeat (10) @(negedge Clock);
    #1;
    chk("mid_clear_run", {31'h0, Cpu_run}, 32'h0);

    // Reset mid-CLEAR with a store and a loader beat on the same edge.
    Reset = 1'b0; Data_write = 1'b1; Data_ad = 16'd3; Data_wdata = 16'h3333;
    @(negedge Clock);
    #1;
    chk("rst_clear_run", {31'h0, Cpu_run}, 32'h0);
    chk("rst_clear_ready", {31'h0, Load_ready}, 32'h1);
    Reset = 1'b1; Load_valid = 1'b0; Data_write = 1'b0;

    // Two beats, then reset on an edge carrying a beat (0xDEAD must not land at address 2).
    for (int b = 0; b < 2; b++) begin
      @(negedge Clock);
      Load_valid = 1'b1; Load_data = 16'h5550 + b[15:0];
    end
    @(negedge Clock);
    Reset = 1'b0; Load_data = 16'hDEAD;
    @(negedge Clock);
    #1;
    chk("rst_load_ready", {31'h0, Load_ready}, 32'h1);
    Reset = 1'b1; Load_valid = 1'b0;
    @(negedge Clock);
    Load_valid = 1'b1; Load_data = 16'hAAAA; Load_last = 1'b1;
    @(negedge Clock);
    Load_valid = 1'b0; Load_last = 1'b0;
    #1;
    chk("ready_fall2", {31'h0, Load_ready}, 32'h0);
    wait_boot(cnt);
    chk("boot3_cycles", cnt, 32'd256);

    rd_instr(16'd0,   16'hAAAA, "stale_pc0");
    rd_instr(16'd1,   16'h5551, "stale_pc1");
    rd_instr(16'd2,   16'h8002, "stale_pc2_no_reset_write");
    rd_instr(16'd100, 16'h8064, "stale_pc100");
    rd_instr(16'd255, 16'h80FF, "full_last_addr");
    sweep_dmem("clr3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
